// File: rtl/hex_view_pkg.sv
// Shared types and constants for the hex debug viewer.
// Holds the mode encoding, the blank pattern and the nibble-to-segment lookup.
package hex_view_pkg;

  typedef enum logic [1:0] {
    MODE_MANUAL    = 2'b00,
    MODE_AUTO_PAGE = 2'b01,
    MODE_AUTO_CH   = 2'b10
  } mode_e;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Active-low segments, bit 6 = g ... bit 0 = a
  function automatic logic [6:0] nib2seg(input logic [3:0] n);
    case (n)
      4'h0: nib2seg = 7'h40;
      4'h1: nib2seg = 7'h79;
      4'h2: nib2seg = 7'h24;
      4'h3: nib2seg = 7'h30;
      4'h4: nib2seg = 7'h19;
      4'h5: nib2seg = 7'h12;
      4'h6: nib2seg = 7'h02;
      4'h7: nib2seg = 7'h78;
      4'h8: nib2seg = 7'h00;
      4'h9: nib2seg = 7'h10;
      4'hA: nib2seg = 7'h08;
      4'hB: nib2seg = 7'h03;
      4'hC: nib2seg = 7'h46;
      4'hD: nib2seg = 7'h21;
      4'hE: nib2seg = 7'h06;
      default: nib2seg = 7'h0E;
    endcase
  endfunction

  function automatic mode_e mode_next(input mode_e m);
    case (m)
      MODE_MANUAL:    mode_next = MODE_AUTO_PAGE;
      MODE_AUTO_PAGE: mode_next = MODE_AUTO_CH;
      default:        mode_next = MODE_MANUAL;
    endcase
  endfunction

endpackage

// File: rtl/hex_view_ctrl_seg7.sv
// Single-digit decoder: nibble + blank + dot -> active-low 8-bit pattern.
module hex_seg7
  import hex_view_pkg::*;
(
  input  logic [3:0] nib,
  input  logic       blank,
  input  logic       dot,
  output logic [7:0] seg
);

  assign seg = {~dot, blank ? SEG_BLANK[6:0] : nib2seg(nib)};

endmodule

// File: rtl/hex_view_ctrl.sv
// Debug viewer: selects one channel, snapshots it, pages it across the
// hex digits, with manual/auto stepping, freeze and change-flash on the dots.
module hex_view_ctrl
  import hex_view_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int NUM_DIGITS = 6,
  parameter int NUM_CH     = 4,
  parameter int TICK_DIV   = 50000000,
  parameter int FLASH_CYC  = 12500000,
  localparam int NNIB  = (DATA_W + 3) / 4,
  localparam int NPAGE = (NNIB + NUM_DIGITS - 1) / NUM_DIGITS,
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int PG_W  = (NPAGE > 1) ? $clog2(NPAGE) : 1
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         BNEXT,
  input  logic                         BMODE,
  input  logic                         FREEZE,
  input  logic [NUM_CH*DATA_W-1:0]     CH_DATA,
  output logic [NUM_DIGITS*8-1:0]      nHEX,
  output logic [CH_W-1:0]              CH_SEL,
  output logic [PG_W-1:0]              PAGE,
  output logic [1:0]                   MODE
);

  localparam int TK_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int FL_W  = (FLASH_CYC > 1) ? $clog2(FLASH_CYC) : 1;
  localparam int PAD_W = NPAGE * NUM_DIGITS * 4;
  localparam logic [CH_W-1:0] CH_LAST   = CH_W'(NUM_CH - 1);
  localparam logic [PG_W-1:0] PG_LAST   = PG_W'(NPAGE - 1);
  localparam logic [TK_W-1:0] TICK_LAST = TK_W'(TICK_DIV - 1);
  localparam logic [FL_W-1:0] FLASH_TOP = FL_W'(FLASH_CYC - 1);

  mode_e                   mode;
  logic [CH_W-1:0]         ch_sel, snap_ch, prev_ch, ch_inc, ch_nxt;
  logic [PG_W-1:0]         page, pg_nxt;
  logic [DATA_W-1:0]       snap, snap_prev, ch_word;
  logic [PAD_W-1:0]        snap_pad;
  logic [TK_W-1:0]         tick_cnt;
  logic [FL_W-1:0]         flash_cnt;
  logic [1:0]              vld_pipe;
  logic [NUM_DIGITS*8-1:0] nhex_q, seg_w;
  logic                    run_auto, tick, snap_load, chg, dot_on;

  assign ch_word   = CH_DATA[ch_sel*DATA_W +: DATA_W];
  assign snap_pad  = PAD_W'(snap);
  // A channel switch forces a reload even when frozen, so the view tracks CH_SEL
  assign snap_load = !FREEZE || (ch_sel != snap_ch);
  // vld_pipe[1] keeps the first post-reset load from looking like a change
  assign chg       = vld_pipe[1] && (snap != snap_prev) && (snap_ch == prev_ch);
  assign dot_on    = chg || (flash_cnt != '0);

  assign run_auto  = (mode != MODE_MANUAL) && !FREEZE;
  assign tick      = run_auto && (tick_cnt == TICK_LAST);
  assign ch_inc    = (ch_sel == CH_LAST) ? '0 : ch_sel + 1'b1;

  always_comb begin
    ch_nxt = ch_sel;
    pg_nxt = page;
    if (mode == MODE_AUTO_CH) begin
      if (NUM_CH > 1) begin
        ch_nxt = ch_inc;
        pg_nxt = '0;
      end
    end else if (page == PG_LAST) begin
      pg_nxt = '0;
      ch_nxt = ch_inc;
    end else begin
      pg_nxt = page + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      mode      <= MODE_MANUAL;
      ch_sel    <= '0;
      page      <= '0;
      snap      <= '0;
      snap_ch   <= '0;
      snap_prev <= '0;
      prev_ch   <= '0;
      tick_cnt  <= '0;
      flash_cnt <= '0;
      vld_pipe  <= '0;
      nhex_q    <= {NUM_DIGITS{8'hC0}};
    end else begin
      vld_pipe  <= {vld_pipe[0], 1'b1};
      if (snap_load) begin
        snap    <= ch_word;
        snap_ch <= ch_sel;
      end
      snap_prev <= snap;
      prev_ch   <= snap_ch;

      if (chg)                  flash_cnt <= FLASH_TOP;
      else if (flash_cnt != '0) flash_cnt <= flash_cnt - 1'b1;

      nhex_q <= seg_w;

      // BMODE beats BNEXT; BNEXT and tick together give one step
      if (BMODE) begin
        mode     <= mode_next(mode);
        tick_cnt <= '0;
      end else if (BNEXT || tick) begin
        ch_sel   <= ch_nxt;
        page     <= pg_nxt;
        tick_cnt <= '0;
      end else if (run_auto) begin
        tick_cnt <= tick_cnt + 1'b1;
      end
    end
  end

  for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_dig
    logic [31:0] nib_idx;
    assign nib_idx = 32'(page) * 32'(NUM_DIGITS) + 32'(d);
    hex_seg7 u_seg (
      .nib   (snap_pad[nib_idx*4 +: 4]),
      .blank (nib_idx >= 32'(NNIB)),
      .dot   (dot_on),
      .seg   (seg_w[d*8 +: 8])
    );
  end

  assign nHEX   = nhex_q;
  assign CH_SEL = ch_sel;
  assign PAGE   = page;
  assign MODE   = mode;

endmodule

// File: tb/tb_hex_view_ctrl.sv
// Directed bench for hex_view_ctrl: a vector table plus hand-written sequences
// for freeze, change-flash and mid-run reset.
module tb_hex_view_ctrl;

  logic        CLK = 1'b0;
  logic        RST, BNEXT, BMODE, FREEZE;
  logic [63:0] CH_DATA;
  logic [47:0] nHEX;
  logic        CH_SEL, PAGE;
  logic [1:0]  MODE;

  hex_view_ctrl #(
    .DATA_W(32), .NUM_DIGITS(6), .NUM_CH(2), .TICK_DIV(4), .FLASH_CYC(3)
  ) dut (
    .CLK(CLK), .RST(RST), .BNEXT(BNEXT), .BMODE(BMODE), .FREEZE(FREEZE),
    .CH_DATA(CH_DATA), .nHEX(nHEX), .CH_SEL(CH_SEL), .PAGE(PAGE), .MODE(MODE)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic        rst, bn, bm, fz;
    logic [31:0] c0, c1;
    logic [47:0] hex;
    logic [1:0]  md;
    logic        pg, ch;
  } vec_t;

  localparam logic [31:0] A  = 32'h1234ABCD;
  localparam logic [31:0] S7 = 32'h00000007;
  localparam logic [47:0] H_RST = 48'hC0C0C0C0C0C0;
  localparam logic [47:0] H_A0  = 48'hB0998883C6A1;
  localparam logic [47:0] H_A1  = 48'hFFFFFFFFF9A4;
  localparam logic [47:0] H_70  = 48'hC0C0C0C0C0F8;
  localparam logic [47:0] H_71  = 48'hFFFFFFFFC0C0;

  int   n_vec = 0;
  int   n_err = 0;
  vec_t tbl[$];

  function automatic vec_t mk(logic rst, logic bn, logic bm, logic fz,
                              logic [31:0] c0, logic [31:0] c1,
                              logic [47:0] hex, logic [1:0] md, logic pg, logic ch);
    vec_t v;
    v.rst = rst; v.bn = bn; v.bm = bm; v.fz = fz;
    v.c0 = c0; v.c1 = c1; v.hex = hex; v.md = md; v.pg = pg; v.ch = ch;
    return v;
  endfunction

  task automatic run(input vec_t v, input string nm, input int idx);
    RST = v.rst; BNEXT = v.bn; BMODE = v.bm; FREEZE = v.fz;
    CH_DATA = {v.c1, v.c0};
    @(posedge CLK);
    #1;
    n_vec++;
    if ({nHEX, MODE, PAGE, CH_SEL} !== {v.hex, v.md, v.pg, v.ch}) begin
      n_err++;
      $display("FAIL %s[%0d] got hex=%h mode=%0d page=%0d ch=%0d want hex=%h mode=%0d page=%0d ch=%0d",
               nm, idx, nHEX, MODE, PAGE, CH_SEL, v.hex, v.md, v.pg, v.ch);
    end
  endtask

  initial begin
    // reset, release, two-cycle latency to the pins
    tbl.push_back(mk(1,0,0,0, A,S7, H_RST, 0,0,0));
    tbl.push_back(mk(1,0,0,0, A,S7, H_RST, 0,0,0));
    tbl.push_back(mk(0,0,0,0, A,S7, H_RST, 0,0,0));
    tbl.push_back(mk(0,0,0,0, A,S7, H_A0,  0,0,0));
    // manual paging and channel wrap
    tbl.push_back(mk(0,1,0,0, A,S7, H_A0,  0,1,0));
    tbl.push_back(mk(0,0,0,0, A,S7, H_A1,  0,1,0));
    tbl.push_back(mk(0,1,0,0, A,S7, H_A1,  0,0,1));
    tbl.push_back(mk(0,0,0,0, A,S7, H_A0,  0,0,1));
    tbl.push_back(mk(0,0,0,0, A,S7, H_70,  0,0,1));
    tbl.push_back(mk(0,1,0,0, A,S7, H_70,  0,1,1));
    tbl.push_back(mk(0,0,0,0, A,S7, H_71,  0,1,1));
    tbl.push_back(mk(0,1,0,0, A,S7, H_71,  0,0,0));
    tbl.push_back(mk(0,0,0,0, A,S7, H_70,  0,0,0));
    tbl.push_back(mk(0,0,0,0, A,S7, H_A0,  0,0,0));
    // into AUTO_CH, channel toggles every TICK_DIV cycles
    tbl.push_back(mk(0,0,1,0, A,S7, H_A0,  1,0,0));
    tbl.push_back(mk(0,0,1,0, A,S7, H_A0,  2,0,0));
    tbl.push_back(mk(0,0,0,0, A,S7, H_A0,  2,0,0));
    tbl.push_back(mk(0,0,0,0, A,S7, H_A0,  2,0,0));
    tbl.push_back(mk(0,0,0,0, A,S7, H_A0,  2,0,0));
    tbl.push_back(mk(0,0,0,0, A,S7, H_A0,  2,0,1));
    tbl.push_back(mk(0,0,0,0, A,S7, H_A0,  2,0,1));
    tbl.push_back(mk(0,0,0,0, A,S7, H_70,  2,0,1));
    tbl.push_back(mk(0,0,0,0, A,S7, H_70,  2,0,1));
    tbl.push_back(mk(0,0,0,0, A,S7, H_70,  2,0,0));
    // BMODE with BNEXT: mode wraps to MANUAL, no step
    tbl.push_back(mk(0,1,1,0, A,S7, H_70,  0,0,0));
    tbl.push_back(mk(0,0,0,0, A,S7, H_A0,  0,0,0));

    for (int i = 0; i < tbl.size(); i++) run(tbl[i], "tbl", i);

    // freeze holds; a channel round trip refreshes the frozen snapshot
    run(mk(0,0,0,1, 32'hFFFF0000,S7, H_A0, 0,0,0), "frz", 0);
    run(mk(0,0,0,1, 32'hFFFF0000,S7, H_A0, 0,0,0), "frz", 1);
    run(mk(0,1,0,1, 32'hFFFF0000,S7, H_A0, 0,1,0), "frz", 2);
    run(mk(0,1,0,1, 32'hFFFF0000,S7, H_A1, 0,0,1), "frz", 3);
    run(mk(0,0,0,1, 32'hFFFF0000,S7, H_A0, 0,0,1), "frz", 4);
    run(mk(0,1,0,1, 32'hFFFF0000,S7, H_70, 0,1,1), "frz", 5);
    run(mk(0,1,0,1, 32'hFFFF0000,S7, H_71, 0,0,0), "frz", 6);
    run(mk(0,0,0,1, 32'hFFFF0000,S7, H_70, 0,0,0), "frz", 7);
    run(mk(0,0,0,1, 32'hFFFF0000,S7, 48'h8E8EC0C0C0C0, 0,0,0), "frz", 8);

    // change flash: FFFF0000 -> 1 -> 2, dots lit for three registered cycles
    run(mk(0,0,0,0, 32'h1,S7, 48'h8E8EC0C0C0C0, 0,0,0), "fl", 0);
    run(mk(0,0,0,0, 32'h1,S7, 48'h404040404079, 0,0,0), "fl", 1);
    run(mk(0,0,0,0, 32'h1,S7, 48'h404040404079, 0,0,0), "fl", 2);
    run(mk(0,0,0,0, 32'h1,S7, 48'h404040404079, 0,0,0), "fl", 3);
    run(mk(0,0,0,0, 32'h1,S7, 48'hC0C0C0C0C0F9, 0,0,0), "fl", 4);
    run(mk(0,0,0,0, 32'h2,S7, 48'hC0C0C0C0C0F9, 0,0,0), "fl", 5);
    run(mk(0,0,0,0, 32'h2,S7, 48'h404040404024, 0,0,0), "fl", 6);
    run(mk(0,0,0,0, 32'h2,S7, 48'h404040404024, 0,0,0), "fl", 7);
    run(mk(0,0,0,0, 32'h2,S7, 48'h404040404024, 0,0,0), "fl", 8);
    run(mk(0,0,0,0, 32'h2,S7, 48'hC0C0C0C0C0A4, 0,0,0), "fl", 9);
    // channel switch: no flash
    run(mk(0,1,0,0, 32'h2,S7, 48'hC0C0C0C0C0A4, 0,1,0), "sw", 0);
    run(mk(0,1,0,0, 32'h2,S7, H_71, 0,0,1), "sw", 1);
    run(mk(0,0,0,0, 32'h2,S7, 48'hC0C0C0C0C0A4, 0,0,1), "sw", 2);
    run(mk(0,0,0,0, 32'h2,S7, H_70, 0,0,1), "sw", 3);
    run(mk(0,0,0,0, 32'h2,S7, H_70, 0,0,1), "sw", 4);

    // reset in AUTO_PAGE with tick and flash counters both non-zero
    run(mk(0,0,1,0, 32'h2,S7,    H_70, 1,0,1), "rst", 0);
    run(mk(0,0,0,0, 32'h2,32'h8, H_70, 1,0,1), "rst", 1);
    run(mk(0,0,0,0, 32'h2,32'h8, 48'h404040404000, 1,0,1), "rst", 2);
    run(mk(1,0,0,0, 32'h2,32'h8, H_RST, 0,0,0), "rst", 3);
    run(mk(0,0,0,0, 32'h2,32'h8, H_RST, 0,0,0), "rst", 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
